keypad_cmd: RTL
===============

KEYPAD_CMD -- requirements
Module: keypad_cmd

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000: clocks per column slot and per debounce sample, minimum 2.
REQ-002 SHALL have parameter DEBOUNCE, default 4: consecutive identical samples that confirm a press or a release, minimum 1.
REQ-003 SHALL have port clock  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rows  input  4  keypad row lines, active-low (pulled up), asynchronous to clock.
REQ-006 SHALL have port status  input  2  calculator status: 2'b01 = busy, any other value = accepting.
REQ-007 SHALL have port cols  output  4  keypad column drive, one-hot-low.
REQ-008 SHALL have port cmd  output  4  command to calculator; 4'hF = no command (idle).

Function
REQ-009 SHALL pass rows through a 2-flop synchronizer before any use; all row references below mean the synchronized value.
REQ-010 SHALL use a single FSM with states SCAN, DEBOUNCE, EMIT, RELEASE.
REQ-011 SCAN: SHALL drive cols 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing every SCAN_DIV clocks, and sample rows on the last clock of each slot.
REQ-012 SCAN: if any row is low at a sample, SHALL freeze cols on the current column, latch the lowest-index low row (row 0 has priority), load debounce count 1, and go to DEBOUNCE.
REQ-013 DEBOUNCE: SHALL sample every SCAN_DIV clocks; latched row still low -> count+1; latched row high -> return to SCAN and advance to the next column.
REQ-014 DEBOUNCE: when count reaches DEBOUNCE, SHALL go to EMIT; with DEBOUNCE=1 it goes to EMIT on the clock after detection.
REQ-015 Key map (row,col) SHALL be: (0,0)=1 (0,1)=2 (0,2)=3 (0,3)=A; (1,0)=4 (1,1)=5 (1,2)=6 (1,3)=B; (2,0)=7 (2,1)=8 (2,2)=9 (2,3)=C; (3,0)=* (3,1)=0 (3,2)=# (3,3)=D.
REQ-016 Command codes SHALL be: digits 0-9 -> 4'h0-4'h9; A -> 4'hA (add); B -> 4'hB (sub); C -> 4'hC (mul); D -> 4'hD (equals); * -> 4'hE (backspace); # -> reserved, no command emitted.
REQ-017 EMIT: while status==2'b01, SHALL hold cmd=4'hF and wait indefinitely, keeping the key pending; release during the wait SHALL NOT cancel it.
REQ-018 EMIT: on the first clock with status!=2'b01, SHALL drive cmd=code for exactly one clock, then go to RELEASE; a # key goes straight to RELEASE with cmd=4'hF.
REQ-019 cmd SHALL be registered and equal 4'hF in every clock except the single emit clock.
REQ-020 RELEASE: SHALL sample every SCAN_DIV clocks and require DEBOUNCE consecutive samples with the latched row high; any low sample resets the count.
REQ-021 RELEASE complete: SHALL return to SCAN at the next column; a key held indefinitely SHALL yield exactly one command.
REQ-022 Other keys pressed while a key is latched SHALL be ignored until RELEASE completes.
REQ-023 Slot/sample counter SHALL be sized clog2(SCAN_DIV); debounce counter SHALL be sized clog2(DEBOUNCE+1); neither SHALL wrap.

Reset
REQ-024 On reset=1 at a rising edge, SHALL set state=SCAN, cols=4'b1110, cmd=4'hF, all counters and latched row/col to 0, and synchronizer flops to 4'hF.
REQ-025 Reset SHALL take priority over all state transitions, including mid-DEBOUNCE, mid-EMIT wait and mid-RELEASE; no command SHALL be emitted on the reset clock or the clock after it.

Verification (SCAN_DIV=4, DEBOUNCE=2)
REQ-026 Reset then no key for 64 clocks -> cols cycles 1110,1101,1011,0111 in 4-clock slots; cmd stays 4'hF.
REQ-027 Hold row1 low while cols=1101 (key 5) for 40 clocks, status=00 -> exactly one clock of cmd=4'h5; cols frozen at 1101 until release is confirmed.
REQ-028 Key D (row3, col3) pressed with status=01 for 50 clocks, then status=00 -> cmd=4'hD for one clock only after status drops; 4'hF before.
REQ-029 Row0 low for one sample only at col0 (bounce) -> return to SCAN, cols advances to 1101, no command.
REQ-030 Key # pressed and released -> cmd never leaves 4'hF; scanning resumes after release.
REQ-031 Reset asserted during EMIT wait (status=01) -> cols=1110, cmd=4'hF, and the pending key is discarded.

Source files
------------

// File: rtl/keypad_cmd.sv
// 4x4 matrix keypad scanner: synchronizes rows, debounces a press, emits one calculator
// command per key press when the calculator is not busy, then waits for a debounced release.
module keypad_cmd #(
   parameter int unsigned SCAN_DIV = 1000,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] rows,
   input  logic [1:0] status,
   output logic [3:0] cols,
   output logic [3:0] cmd
);

   localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DebW = $clog2(DEBOUNCE + 1);
   localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
   localparam logic [DebW-1:0] DebDone = DebW'(DEBOUNCE);

   typedef enum logic [1:0] {
      StScan,
      StDebounce,
      StEmit,
      StRelease
   } state_e;

   state_e          state;
   logic [3:0]      rows_meta;
   logic [3:0]      rows_sync;
   logic [DivW-1:0] div_cnt;
   logic [DebW-1:0] deb_cnt;
   logic [1:0]      col_idx;
   logic [1:0]      row_idx;
   logic [1:0]      low_row;
   logic            tick;
   logic            row_low;

   function automatic logic [3:0] col_drive(input logic [1:0] idx);
      col_drive = ~(4'b0001 << idx);
   endfunction

   // The # key (row 3, col 2) falls through to the idle code, so it never emits.
   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0:    key_code = 4'h1;
         4'h1:    key_code = 4'h2;
         4'h2:    key_code = 4'h3;
         4'h3:    key_code = 4'hA;
         4'h4:    key_code = 4'h4;
         4'h5:    key_code = 4'h5;
         4'h6:    key_code = 4'h6;
         4'h7:    key_code = 4'hB;
         4'h8:    key_code = 4'h7;
         4'h9:    key_code = 4'h8;
         4'hA:    key_code = 4'h9;
         4'hB:    key_code = 4'hC;
         4'hC:    key_code = 4'hE;
         4'hD:    key_code = 4'h0;
         4'hF:    key_code = 4'hD;
         default: key_code = 4'hF;
      endcase
   endfunction

   assign tick    = (div_cnt == DivLast);
   assign row_low = ~rows_sync[row_idx];

   // Row 0 wins when several rows are low in the same column.
   always_comb begin
      low_row = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!rows_sync[i]) low_row = 2'(i);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= StScan;
         rows_meta <= 4'hF;
         rows_sync <= 4'hF;
         div_cnt   <= '0;
         deb_cnt   <= '0;
         col_idx   <= 2'd0;
         row_idx   <= 2'd0;
         cols      <= 4'b1110;
         cmd       <= 4'hF;
      end else begin
         rows_meta <= rows;
         rows_sync <= rows_meta;
         div_cnt   <= tick ? '0 : div_cnt + 1'b1;
         cmd       <= 4'hF;
         unique case (state)
            StScan: begin
               if (tick) begin
                  if (rows_sync != 4'hF) begin
                     row_idx <= low_row;
                     deb_cnt <= DebW'(1);
                     state   <= StDebounce;
                  end else begin
                     col_idx <= col_idx + 2'd1;
                     cols    <= col_drive(col_idx + 2'd1);
                  end
               end
            end
            StDebounce: begin
               if (deb_cnt == DebDone) begin
                  deb_cnt <= '0;
                  state   <= StEmit;
               end else if (tick) begin
                  if (row_low) begin
                     deb_cnt <= deb_cnt + 1'b1;
                  end else begin
                     deb_cnt <= '0;
                     col_idx <= col_idx + 2'd1;
                     cols    <= col_drive(col_idx + 2'd1);
                     state   <= StScan;
                  end
               end
            end
            StEmit: begin
               if (status != 2'b01) begin
                  cmd   <= key_code(row_idx, col_idx);
                  state <= StRelease;
               end
            end
            StRelease: begin
               if (tick) begin
                  if (!row_low) begin
                     if (deb_cnt + 1'b1 == DebDone) begin
                        deb_cnt <= '0;
                        col_idx <= col_idx + 2'd1;
                        cols    <= col_drive(col_idx + 2'd1);
                        state   <= StScan;
                     end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                     end
                  end else begin
                     deb_cnt <= '0;
                  end
               end
            end
            default: state <= StScan;
         endcase
      end
   end

endmodule
